// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: decision encodings,
// branch condition codes and 2-bit saturating counter states.
package bpu_pkg;

  typedef enum logic [1:0] {
    DEC_SEQ  = 2'b00,
    DEC_TGT  = 2'b01,
    DEC_JALR = 2'b10
  } dec_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Saturating step of a 2-bit counter toward taken / not-taken.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      case (cur)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        default: nxt = ST;
      endcase
    end else begin
      case (cur)
        ST:      nxt = WT;
        WT:      nxt = WNT;
        default: nxt = SNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_compare.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from its funct3 code and two XLEN-bit operands.
module branch_compare
  import bpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            cond_true
);

  // Condition select; reserved codes resolve as not taken.
  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      F3_BEQ:  cond_true = (data1 == data2);
      F3_BNE:  cond_true = (data1 != data2);
      F3_BLT:  cond_true = ($signed(data1) <  $signed(data2));
      F3_BGE:  cond_true = ($signed(data1) >= $signed(data2));
      F3_BLTU: cond_true = (data1 <  data2);
      F3_BGEU: cond_true = (data1 >= data2);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: bimodal table of 2-bit saturating counters indexed by
// PC word address, plus EX-stage branch/jump resolution and flush request.
// Optional macro BPU_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_data1,
  input  logic [XLEN-1:0] ex_data2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic [1:0]      decision,
  output logic            mispredict
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  ctr_e             bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond_true;
  dec_e             dec;
  logic             taken;
  logic             upd;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3    (ex_funct3),
    .data1     (ex_data1),
    .data2     (ex_data2),
    .cond_true (cond_true)
  );

  // Fetch-side prediction: MSB of the indexed counter, no bypass from EX.
  assign pred_taken = bht[if_idx][1];

  // Resolution priority: JALR over JAL over conditional branch.
  always_comb begin
    dec = DEC_SEQ;
    if (ex_valid) begin
      if (ex_jalr)                     dec = DEC_JALR;
      else if (ex_jump)                dec = DEC_TGT;
      else if (ex_branch && cond_true) dec = DEC_TGT;
    end
  end

  assign decision   = dec;
  assign taken      = (dec != DEC_SEQ);
  assign upd        = ex_valid & ~ex_stall & ex_branch;
  assign mispredict = ex_valid & ~ex_stall &
                      (ex_jalr | ex_jump | (ex_branch & (taken != ex_pred_taken)));

  // Counter table: reset to weakly not-taken wins over any coincident update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
    end else if (upd) begin
      bht[ex_idx] <= ctr_next(bht[ex_idx], taken);
    end
  end

`ifdef BPU_STATS_EN
  // Saturating event counters for resolved branches and their mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if ((taken != ex_pred_taken) && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and PC width.
REQ-002 Parameter BHT_ENTRIES, default 64, branch-history-table depth; power of two, at least 4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_pc  in  XLEN  fetch-stage PC to predict.
REQ-006 pred_taken  out  1  prediction for if_pc; combinational read of the table.
REQ-007 ex_valid  in  1  EX stage holds a valid instruction.
REQ-008 ex_stall  in  1  EX stage stalled; blocks table and counter updates.
REQ-009 ex_branch  in  1  conditional branch (B-type).
REQ-010 ex_jump  in  1  JAL.
REQ-011 ex_jalr  in  1  JALR.
REQ-012 ex_funct3  in  3  branch condition code.
REQ-013 ex_data1, ex_data2  in  XLEN  each, compared operands.
REQ-014 ex_pc  in  XLEN  PC of the EX-stage instruction.
REQ-015 ex_pred_taken  in  1  prediction made at fetch for this instruction.
REQ-016 decision  out  2  00 = sequential, 01 = branch/JAL target, 10 = JALR target.
REQ-017 mispredict  out  1  pipeline flush request.

Function
REQ-018 Index = PC[log2(BHT_ENTRIES)+1:2]; one 2-bit saturating counter per entry; pred_taken = counter[1] at index(if_pc).
REQ-019 Conditions: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE, all over XLEN bits; 010/011 = not taken.
REQ-020 decision is combinational and gated by ex_valid: ex_jalr -> 10; else ex_jump -> 01; else ex_branch and condition true -> 01; else 00. Priority: JALR > JAL > branch.
REQ-021 Resolved outcome: taken = (decision != 00).
REQ-022 mispredict = ex_valid & ~ex_stall & (ex_jalr | ex_jump | (ex_branch & (taken != ex_pred_taken))). Jumps always flush; the table does not track jumps.
REQ-023 Update: on a clock edge with ex_valid & ~ex_stall & ex_branch, the counter at index(ex_pc) increments (saturate at 11) if taken, else decrements (saturate at 00).
REQ-024 No other event changes the table; jumps and invalid or stalled slots leave it untouched.
REQ-025 Same-cycle lookup and update to one index: pred_taken returns the pre-update value; no bypass.
REQ-026 Zero-cycle resolution latency; one-cycle latency from resolution to the updated prediction.

Reset
REQ-027 rst clears every counter to 01 (weakly not-taken) in the same edge, overriding any coincident update.
REQ-028 During rst, decision and mispredict follow REQ-020 and REQ-022 combinationally; pred_taken reads 0 from the cycle after rst.
REQ-029 rst asserted mid-operation discards that cycle's update.

Configuration
REQ-030 Macro BPU_STATS_EN: when defined, adds outputs stat_branches and stat_mispredicts (both 32-bit), counting qualifying updates (REQ-023) and mispredicting branches, saturating at all-ones, cleared by rst.
REQ-031 When BPU_STATS_EN is undefined, the stat ports and their logic are absent; all other behaviour is identical.

Structure
REQ-032 Package bpu_pkg holds the decision encodings (DEC_SEQ, DEC_TGT, DEC_JALR), funct3 condition constants and counter-state constants (SNT, WNT, WT, ST).
REQ-033 One sub-module, branch_compare (XLEN-parametric; funct3, data1, data2 -> cond_true), is instantiated once.

Verification
REQ-034 rst, then if_pc=0x100 -> pred_taken=0; all entries read 01.
REQ-035 BEQ at ex_pc=0x100, data1=data2=5, ex_pred_taken=0 -> decision=01, mispredict=1; next cycle pred_taken for 0x100 = 1.
REQ-036 BLT with data1=0xFFFFFFFF, data2=1 -> taken; BLTU with the same operands -> not taken.
REQ-037 Four taken updates, then one not-taken at 0x200 -> counter 11, then 10; pred_taken stays 1.
REQ-038 ex_jalr=1 and ex_jump=1 together -> decision=10, mispredict=1, table unchanged; ex_stall=1 with a BEQ -> no update.
REQ-039 BHT_ENTRIES=64: a branch at 0x104 and one at 0x204 alias to the same index; updating one changes the other's prediction.
